// File: rtl/disp_fetch_pkg.sv
// disp_fetch_pkg: shared types and constants for the display frame-fetch controller.
//   fetch_state_t    - controller FSM states
//   OKAY             - AXI read response value for a clean beat
//   FRAME_BEATS, BURSTS_PER_FRAME, BURST_BYTES - derived sizes for the default 640x480 mode
//   frame_beats()    - 64-bit beats per frame for any resolution (2 pixels per beat)
package disp_fetch_pkg;

  typedef enum logic [2:0] {IDLE, RSTF, WAIT, ADDR, DATA} fetch_state_t;

  localparam logic [1:0] OKAY = 2'b00;

  localparam int H_PIXELS_DEF  = 640;
  localparam int V_LINES_DEF   = 480;
  localparam int BURST_LEN_DEF = 16;

  localparam int FRAME_BEATS      = H_PIXELS_DEF * V_LINES_DEF / 2;
  localparam int BURSTS_PER_FRAME = FRAME_BEATS / BURST_LEN_DEF;
  localparam int BURST_BYTES      = BURST_LEN_DEF * 8;

  function automatic int frame_beats(input int h, input int v);
    return h * v / 2;
  endfunction

endpackage

// File: rtl/disp_fetch_addr.sv
// disp_fetch_addr: burst-offset counter for one frame.
//   clk, rst  - clock, synchronous active-high reset
//   clr       - restart the frame (offset and burst count to 0)
//   inc       - advance to the next burst
//   offset    - byte offset of the current burst from the frame base
//   last      - current burst is the final one of the frame
module disp_fetch_addr
  import disp_fetch_pkg::*;
#(
  parameter int BURSTS = BURSTS_PER_FRAME,
  parameter int STEP   = BURST_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] offset,
  output logic        last
);

  localparam int CW = (BURSTS > 1) ? $clog2(BURSTS) : 1;

  logic [CW-1:0] cnt;

  // The offset wraps naturally modulo 2^32; the burst count alone decides "last".
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      offset <= '0;
    end else if (inc) begin
      cnt    <= cnt + CW'(1);
      offset <= offset + 32'(STEP);
    end
  end

  assign last = (cnt == CW'(BURSTS - 1));

endmodule

// File: rtl/disp_fetch_ctrl.sv
// disp_fetch_ctrl: frame-fetch controller, AXI4 read master -> display FIFO write port.
// Build option: DISP_FETCH_RRESP_CHK_EN enables the sticky RD_ERR flag on non-OKAY beats;
// without it RD_ERR is tied low and RRESP is ignored.
// Ports:
//   ACLK, ARST               clock, synchronous active-high reset
//   DISPON, DISPSTART        display enable, one-cycle frame-start pulse
//   DISPADDR                 frame base byte address (bits [6:0] ignored)
//   BUF_WCOUNT               FIFO write-side fill level
//   ARADDR/ARLEN/ARVALID/ARREADY   AXI read address channel
//   RDATA/RRESP/RLAST/RVALID/RREADY AXI read data channel
//   FIFORST, FIFOWR, FIFOIN  FIFO reset, write strobe, write data
//   FETCH_BUSY, RD_ERR       activity, sticky read-error flag
module disp_fetch_ctrl
  import disp_fetch_pkg::*;
#(
  parameter int H_PIXELS   = H_PIXELS_DEF,
  parameter int V_LINES    = V_LINES_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int FIFO_DEPTH = 512,
  parameter int RST_CYCLES = 8
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic        DISPSTART,
  input  logic [31:0] DISPADDR,
  input  logic [9:0]  BUF_WCOUNT,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        FIFORST,
  output logic        FIFOWR,
  output logic [63:0] FIFOIN,
  output logic        FETCH_BUSY,
  output logic        RD_ERR
);

  localparam int N_BURSTS = frame_beats(H_PIXELS, V_LINES) / BURST_LEN;
  localparam int B_BYTES  = BURST_LEN * 8;
  localparam int RW       = $clog2(RST_CYCLES + 1);

  fetch_state_t  state, state_nxt;
  logic [RW-1:0] rst_cnt;
  logic          restart_req;
  logic          room, beat, burst_done, restart;
  logic          addr_inc, addr_clr, last_burst;
  logic [31:0]   offset, base;

  assign ARLEN = 8'(BURST_LEN - 1);
  assign base  = {DISPADDR[31:7], 7'b0};

  // Whole burst must fit with two words of slack, so beats never need back-pressure.
  assign room       = (32'(BUF_WCOUNT) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH - 2);
  assign beat       = RVALID & RREADY;
  assign burst_done = beat & RLAST;
  // A start pulse in the deciding cycle counts as well as one latched earlier.
  assign restart    = restart_req | DISPSTART;

  disp_fetch_addr #(.BURSTS(N_BURSTS), .STEP(B_BYTES)) u_addr (
    .clk    (ACLK),
    .rst    (ARST),
    .clr    (addr_clr),
    .inc    (addr_inc),
    .offset (offset),
    .last   (last_burst)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_inc  = 1'b0;
    addr_clr  = 1'b0;
    unique case (state)
      IDLE: if (DISPSTART && DISPON) state_nxt = RSTF;
      RSTF: begin
        addr_clr = 1'b1;
        if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = WAIT;
      end
      WAIT: begin
        if (restart)      state_nxt = DISPON ? RSTF : IDLE;
        else if (!DISPON) state_nxt = IDLE;
        else if (room)    state_nxt = ADDR;
      end
      // ARVALID is held until accepted, whatever else happens.
      ADDR: if (ARREADY) state_nxt = DATA;
      // Every beat through RLAST is consumed before any restart or stop.
      DATA: if (burst_done) begin
        if (restart)                     state_nxt = DISPON ? RSTF : IDLE;
        else if (!DISPON || last_burst)  state_nxt = IDLE;
        else begin
          state_nxt = WAIT;
          addr_inc  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST)                rst_cnt <= '0;
    else if (state == RSTF)  rst_cnt <= rst_cnt + RW'(1);
    else                     rst_cnt <= '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARST)
      restart_req <= 1'b0;
    else if (state_nxt == RSTF || state_nxt == IDLE)
      restart_req <= 1'b0;
    else if (DISPSTART && (state == WAIT || state == ADDR || state == DATA))
      restart_req <= 1'b1;
  end

  // Outputs are registered decodes of the next state, so they line up with the state.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      ARADDR     <= '0;
      FIFORST    <= 1'b0;
      FIFOWR     <= 1'b0;
      FIFOIN     <= '0;
      FETCH_BUSY <= 1'b0;
    end else begin
      ARVALID    <= (state_nxt == ADDR);
      RREADY     <= (state_nxt == DATA);
      FIFORST    <= (state_nxt == RSTF);
      FETCH_BUSY <= (state_nxt != IDLE);
      FIFOWR     <= beat;
      if (beat) FIFOIN <= RDATA;
      // Loaded only on entry to ADDR, so it stays stable while ARVALID is high.
      if (state != ADDR && state_nxt == ADDR) ARADDR <= base + offset;
    end
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^DISPADDR[6:0];

`ifdef DISP_FETCH_RRESP_CHK_EN
  always_ff @(posedge ACLK) begin
    if (ARST)                                    RD_ERR <= 1'b0;
    else if (state != RSTF && state_nxt == RSTF) RD_ERR <= 1'b0;
    else if (beat && RRESP != OKAY)              RD_ERR <= 1'b1;
  end
`else
  assign RD_ERR = 1'b0;
  logic unused_rresp;
  assign unused_rresp = ^RRESP;
`endif

endmodule

// File: doc/disp_fetch_ctrl.md
# disp_fetch_ctrl

Frame-fetch controller for the display path: issues AXI4 read bursts from VRAM and streams the returned 64-bit words into the display FIFO write port. It sits in the ACLK domain between the AXI read master interface and the dual-clock display buffer. Each burst is gated by the FIFO write-side fill level. At every frame start it resets the FIFO and restarts fetching from the frame base address.

## Interface
- H_PIXELS, 640, active pixels per line
- V_LINES, 480, active lines per frame
- BURST_LEN, 16, beats per AXI burst (64-bit beats; 2 pixels per beat)
- FIFO_DEPTH, 512, FIFO write-side depth in 64-bit words
- RST_CYCLES, 8, cycles FIFORST is held high

Ports:
- ACLK  in  1  system/AXI clock
- ARST  in  1  reset, synchronous, active-high
- DISPON  in  1  display enable
- DISPSTART  in  1  one-cycle frame-start pulse, ACLK-synchronous
- DISPADDR  in  32  frame base byte address; bits [6:0] ignored (treated as 0)
- BUF_WCOUNT  in  10  FIFO write-side data count
- ARADDR  out  32  burst address
- ARLEN  out  8  constant BURST_LEN-1
- ARVALID  out  1  address valid
- ARREADY  in  1  address accepted
- RDATA  in  64  read data
- RRESP  in  2  read response
- RLAST  in  1  last beat
- RVALID  in  1  data valid
- RREADY  out  1  data ready
- FIFORST  out  1  FIFO reset
- FIFOWR  out  1  FIFO write strobe
- FIFOIN  out  64  FIFO write data
- FETCH_BUSY  out  1  high outside IDLE
- RD_ERR  out  1  sticky read-error flag

## Operation
- Frame size: FRAME_BEATS = H_PIXELS*V_LINES/2 (153600 by default); bursts per frame = FRAME_BEATS/BURST_LEN (9600). A 32-bit byte offset advances by BURST_LEN*8 (128) per burst.
- ARADDR = {DISPADDR[31:7],7'b0} + offset, computed modulo 2^32. Bursts are 128-byte aligned and never cross a 4 KB boundary.
- FSM states:
  - IDLE: DISPSTART & DISPON -> RSTF.
  - RSTF: FIFORST high for RST_CYCLES cycles; offset cleared -> WAIT.
  - WAIT: when BUF_WCOUNT + BURST_LEN <= FIFO_DEPTH - 2 -> ADDR.
  - ADDR: ARVALID high, held until ARREADY -> DATA.
  - DATA: RREADY high; on RVALID&RLAST, if last burst of frame -> IDLE, else offset += 128 and -> WAIT.
- At most one burst is outstanding.
- DISPSTART while the FSM is in WAIT, ADDR or DATA: latch a restart request. The current AXI transaction always completes (ARVALID is never dropped before ARREADY; all beats through RLAST are consumed). The FSM then goes to RSTF, or to IDLE if DISPON is low.
- DISPON low while active: finish the outstanding burst, then -> IDLE. No new ARVALID is issued.
- ARST at any point: all state is cleared immediately, even mid-burst. System-level ARST also resets the interconnect.

## Timing
- Reset values: ARVALID=0, RREADY=0, ARADDR=0, FIFORST=0, FIFOWR=0, FIFOIN=0, FETCH_BUSY=0, RD_ERR=0. ARLEN is constant.
- All outputs are registered.
- FIFOWR/FIFOIN follow an accepted beat (RVALID&RREADY) by exactly 1 cycle.
- Beats arriving during DATA are never back-pressured; the room check in WAIT guarantees space.
- ARADDR is stable while ARVALID is high.
- DISPSTART to FIFORST rising (from IDLE): 1 cycle. FIFORST falling to first ARVALID is at least 1 cycle.

## Configuration
- DISP_FETCH_RRESP_CHK_EN defined: any accepted beat with RRESP != 2'b00 sets RD_ERR. RD_ERR stays high until ARST or the next entry into RSTF. Data is still written to the FIFO.
- Undefined: RD_ERR is tied to 0 and RRESP is ignored.

## Structure
- Package disp_fetch_pkg holds:
  - FSM state enum (IDLE, RSTF, WAIT, ADDR, DATA)
  - AXI response constant OKAY
  - localparams FRAME_BEATS, BURSTS_PER_FRAME, BURST_BYTES
- Sub-module disp_fetch_addr: the burst-offset counter and last-burst detect (increment, clear, last flag).

## Test plan
- Reset, then DISPON=1, DISPSTART pulse, DISPADDR=0x1000_0000, ARREADY/RVALID always 1, BUF_WCOUNT=0 -> FIFORST high 8 cycles; first ARADDR 0x1000_0000, ARLEN=15; 9600 bursts, last ARADDR 0x1012_BF80; 153600 FIFOWR pulses; then IDLE.
- BUF_WCOUNT held at 500 -> no ARVALID. Drop it to 494 -> ARVALID next cycle.
- DISPSTART mid-burst (beat 5 of 16) -> remaining 11 beats consumed and written; then FIFORST, and ARADDR restarts at base.
- DISPON low while ARVALID high and ARREADY delayed 10 cycles -> ARVALID held until ARREADY; burst completes; IDLE; no further ARVALID.
- DISPADDR=0xFFFF_FF80 -> second burst ARADDR 0x0000_0000 (wrap).
- With DISP_FETCH_RRESP_CHK_EN, RRESP=2'b10 on one beat -> RD_ERR=1 until next RSTF. Without the macro -> RD_ERR stays 0.
